// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: opcodes, FSM encodings, bus widths and op decode helpers.
package mem_access_pkg;

   localparam int REG_BUS_W  = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_BUS_W-1:0]  ZERO_WORD     = '0;
   localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
   localparam logic                  WRITE_ENABLE  = 1'b1;
   localparam logic                  WRITE_DISABLE = 1'b0;

   typedef enum logic [3:0] {
      MEM_NOP = 4'd0,
      MEM_LB  = 4'd1,
      MEM_LH  = 4'd2,
      MEM_LW  = 4'd3,
      MEM_LBU = 4'd4,
      MEM_LHU = 4'd5,
      MEM_SB  = 4'd6,
      MEM_SH  = 4'd7,
      MEM_SW  = 4'd8
   } mem_op_e;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ACCESS    = 2'd1;
   localparam logic [1:0] ST_WAIT_LAST = 2'd2;
   localparam logic [1:0] ST_DONE      = 2'd3;

   function automatic logic op_is_load(input mem_op_e op);
      return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
             (op == MEM_LBU) || (op == MEM_LHU);
   endfunction

   function automatic logic op_is_store(input mem_op_e op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   // Index of the final byte of the access (n-1 for n = 1, 2, 4).
   function automatic logic [1:0] op_last_idx(input mem_op_e op);
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
         MEM_LW, MEM_SW:          return 2'd3;
         default:                 return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ext.sv
// Load result formatting: selects byte/half/word from the gathered buffer and sign/zero extends it.
module mem_ext
   import mem_access_pkg::*;
(
   input  mem_op_e              op,
   input  logic [REG_BUS_W-1:0] data_buf,
   input  logic [REG_BUS_W-1:0] pass_val,
   output logic [REG_BUS_W-1:0] ext_val
);

   always_comb begin
      ext_val = pass_val;
      case (op)
         MEM_LB:  ext_val = {{24{data_buf[7]}}, data_buf[7:0]};
         MEM_LBU: ext_val = {24'h0, data_buf[7:0]};
         MEM_LH:  ext_val = {{16{data_buf[15]}}, data_buf[15:0]};
         MEM_LHU: ext_val = {16'h0, data_buf[15:0]};
         MEM_LW:  ext_val = data_buf;
         default: ext_val = pass_val;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM stage: byte-serial load/store engine holding the pipeline until the access completes.
// Optional MEM_IO_WAIT_EN adds io_buffer_full_in to hold stores to the I/O window (a[17:16]==2'b11).
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
)(
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rdy_in,
   input  logic                  stall_in,
   input  logic [3:0]            mem_op_in,
   input  logic [ADDR_W-1:0]     mem_addr_in,
   input  logic [REG_BUS_W-1:0]  mem_sdata_in,
   input  logic                  rd_in,
   input  logic [REG_BUS_W-1:0]  rd_val_in,
   input  logic [REG_ADDR_W-1:0] rd_addr_in,
`ifdef MEM_IO_WAIT_EN
   input  logic                  io_buffer_full_in,
`endif
   output logic                  rd_mem_out,
   output logic [REG_BUS_W-1:0]  rd_val_mem_out,
   output logic [REG_ADDR_W-1:0] rd_addr_mem_out,
   output logic                  stall_req_out,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_W-1:0]     mem_a,
   output logic                  mem_wr
);

   mem_op_e              op;
   logic                 is_load;
   logic                 is_store;
   logic                 is_mem;
   logic [1:0]           last_idx;
   logic [1:0]           state;
   logic [1:0]           cnt;
   logic [1:0]           prev_cnt;
   logic [REG_BUS_W-1:0] data_buf;
   logic [REG_BUS_W-1:0] ext_val;
   logic [ADDR_W-1:0]    issue_addr;
   logic                 io_wait;
   logic                 adv;

   assign op       = mem_op_e'(mem_op_in);
   assign is_load  = op_is_load(op);
   assign is_store = op_is_store(op);
   assign is_mem   = is_load || is_store;
   assign last_idx = op_last_idx(op);
   assign prev_cnt = cnt - 2'd1;

   assign issue_addr = mem_addr_in + ADDR_W'(cnt);

`ifdef MEM_IO_WAIT_EN
   assign io_wait = (state == ST_ACCESS) && is_store &&
                    (issue_addr[17:16] == 2'b11) && io_buffer_full_in;
`else
   assign io_wait = 1'b0;
`endif

   assign adv = rdy_in && !io_wait;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state    <= ST_IDLE;
         cnt      <= 2'd0;
         data_buf <= ZERO_WORD;
      end else if (adv) begin
         case (state)
            ST_IDLE: begin
               if (is_mem) begin
                  state <= ST_ACCESS;
                  cnt   <= 2'd0;
               end
            end
            ST_ACCESS: begin
               // RAM data lags its address by one cycle, so this cycle returns byte cnt-1.
               if (is_load && (cnt != 2'd0))
                  data_buf[{prev_cnt, 3'b000} +: 8] <= mem_din;
               cnt <= cnt + 2'd1;
               if (cnt == last_idx)
                  state <= is_load ? ST_WAIT_LAST : ST_DONE;
            end
            ST_WAIT_LAST: begin
               data_buf[{last_idx, 3'b000} +: 8] <= mem_din;
               state <= ST_DONE;
            end
            default: begin
               if (!stall_in)
                  state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      mem_a    = '0;
      mem_dout = 8'h00;
      mem_wr   = WRITE_DISABLE;
      case (state)
         ST_ACCESS: begin
            // While frozen, re-present the last issued address so the byte pending capture
            // is the one on mem_din in the first cycle after rdy_in returns.
            if (rdy_in || (cnt == 2'd0))
               mem_a = issue_addr;
            else
               mem_a = mem_addr_in + ADDR_W'(prev_cnt);
            if (is_store) begin
               mem_dout = mem_sdata_in[{cnt, 3'b000} +: 8];
               mem_wr   = adv ? WRITE_ENABLE : WRITE_DISABLE;
            end
         end
         ST_WAIT_LAST: begin
            mem_a = mem_addr_in + ADDR_W'(last_idx);
         end
         default: ;
      endcase
   end

   mem_ext u_ext (
      .op       (op),
      .data_buf (data_buf),
      .pass_val (rd_val_in),
      .ext_val  (ext_val)
   );

   always_comb begin
      rd_mem_out      = rd_in;
      rd_addr_mem_out = rd_addr_in;
      if (!is_mem)
         rd_val_mem_out = rd_val_in;
      else if (state == ST_DONE)
         rd_val_mem_out = ext_val;
      else
         rd_val_mem_out = ZERO_WORD;
      stall_req_out = is_mem && (state != ST_DONE);
   end

   a_rd_lat: assert property (@(posedge clk_in) RD_LAT == 1);

   // ex_mem must hold the instruction steady for the whole access.
   a_op_stable: assert property (@(posedge clk_in) disable iff (!rst_n_in)
                                 (state != ST_IDLE) |-> $stable(mem_op_in));

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
MEM stage of the 5-stage RISC-V core. It sits between the ex_mem pipeline register and the mem_wb pipeline register.
- Executes loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over the 8-bit byte-serial RAM port, one byte per cycle.
- Passes non-memory results through unchanged.
- Holds the pipeline through stall_req_out until the access completes.

Parameters:
ADDR_W, 32, memory address width
RD_LAT, 1, RAM read latency in cycles (only value 1 is supported)

Ports:
clk_in  in  1  clock
rst_n_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global ready; low freezes the block
stall_in  in  1  stall[4] from the stall controller; high means mem_wb will not capture this cycle
mem_op_in  in  4  memory opcode (package enum; MEM_NOP = non-memory instruction)
mem_addr_in  in  32  effective address from EX
mem_sdata_in  in  32  store data (rs2)
rd_in  in  1  write-enable from EX
rd_val_in  in  32  ALU result from EX
rd_addr_in  in  5  destination register from EX
rd_mem_out  out  1  write-enable to mem_wb
rd_val_mem_out  out  32  result to mem_wb
rd_addr_mem_out  out  5  destination register to mem_wb
stall_req_out  out  1  stall request to the stall controller
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  1 = write, 0 = read

Behaviour:
- States: IDLE, ACCESS, WAIT_LAST, DONE. Byte counter cnt is 2 bits. Byte count n is 1, 2 or 4 by op width.
- Reset (async, rst_n_in=0): state=IDLE, cnt=0, data buffer=0. The RAM outputs mem_a=0, mem_dout=0, mem_wr=0.
- Output values on reset and in IDLE:
  - With MEM_NOP: rd_* outputs mirror the inputs combinationally.
  - With a memory op: rd_mem_out=rd_in, rd_val_mem_out=0, rd_addr_mem_out=rd_addr_in.
- IDLE:
  - Memory op and rdy_in=1: go to ACCESS, cnt=0.
  - stall_req_out=1 combinationally whenever a memory op is present and state≠DONE.
- ACCESS:
  - Drive mem_a=mem_addr_in+cnt. Add in 32 bits; wrap-around at 0xFFFFFFFF is allowed.
  - Store: mem_wr=1, mem_dout=mem_sdata_in[8cnt+7:8cnt].
  - Load: mem_wr=0, mem_dout=0. mem_din is valid the cycle after its address is driven; byte cnt-1 is captured into buffer[8(cnt-1)+7 : 8(cnt-1)].
  - cnt increments each cycle. After byte n-1: a load goes to WAIT_LAST, a store goes to DONE.
- WAIT_LAST: capture the final byte and go to DONE. mem_a holds the last address; mem_wr=0.
- DONE:
  - stall_req_out=0.
  - rd_val_mem_out=buffer, extended per op: LB/LH sign-extend, LBU/LHU zero-extend, stores output rd_val_in.
  - Leave to IDLE at the next edge with stall_in=0. With stall_in=1, hold DONE and its output values.
- Latency from op arrival (cycle 0):
  - LW: stall cycles 0–5, result cycle 6.
  - LB: stall cycles 0–2, result cycle 3.
  - SW: stall cycles 0–4, release cycle 5.
  - SB: stall cycles 0–1, release cycle 2.
- rdy_in=0: all state frozen, mem_wr forced 0, no byte issued or captured. A load resumes by re-issuing the frozen address, so the data alignment stays correct.
- Reset mid-operation: immediate abort to IDLE. No further writes; partially written bytes remain in RAM.
- Inputs are held stable by ex_mem while stall_req_out=1. Any mem_op_in change while not in IDLE is illegal and is covered by an assertion.

Optional Feature:
MEM_IO_WAIT_EN
- Defined: input io_buffer_full_in (1) is added. A store byte whose address has mem_a[17:16]==2'b11 is not issued while io_buffer_full_in=1. In that cycle mem_wr=0 and cnt holds.
- Undefined: the port is absent and stores never wait.

Decomposition:
- Shared define.v holds: MEM_* opcode constants (MEM_NOP=0, LB, LH, LW, LBU, LHU, SB, SH, SW); state encodings; RegBus/RegAddrBus widths; ZeroWord; NOPRegAdder; WriteEnable/WriteDisable.
- One sub-module: mem_ext, a combinational width select plus sign/zero extension of the buffer by op.

Test Plan:
- LW @0x100, RAM bytes 11 22 33 44 → mem_a 0x100–0x103 in cycles 1–4, mem_wr=0, stall_req_out high for 6 cycles, rd_val_mem_out=0x44332211 in cycle 6.
- LB @0x80 (byte 0x80) → 0xFFFFFF80. LBU same address → 0x00000080. LHU @0x90 (0xFE,0xFF) → 0x0000FFFE.
- SH 0x1234ABCD @0x200 → cycle 1: a=0x200 dout=0xCD wr=1; cycle 2: a=0x201 dout=0xAB wr=1; stall low in cycle 3.
- Non-memory ADD, rd_val_in=0x5, rd_addr=3 → stall_req_out=0, outputs equal inputs in the same cycle.
- rdy_in low for 2 cycles mid-LW → mem_wr=0, no captures, correct 0x44332211 two cycles later. stall_in=1 in DONE → value held.
- rst_n_in pulsed low mid-SW after 2 bytes → all outputs 0 immediately, IDLE, only bytes 0–1 written.
